// File: rtl/sdm_pkg.sv
// Shared Q15 sample type and constants for the sigma-delta signal chain.
package sdm_pkg;

  typedef logic signed [15:0] q15_t;

  localparam q15_t Q15_HALF      = q15_t'(16384);
  localparam q15_t Q15_QUARTER   = q15_t'(8192);
  localparam q15_t Q15_MINUS_ONE = q15_t'(-32768);

endpackage

// File: rtl/avg_filter_ring.sv
// N-deep circular sample history; presents the entry about to be overwritten.
module avg_filter_ring #(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic signed [DATA_W-1:0] data_in,
  output logic signed [DATA_W-1:0] oldest
);

  localparam int unsigned N = 1 << LOG2_N;

  logic signed [DATA_W-1:0] mem [N];
  logic        [LOG2_N-1:0] wp;

  assign oldest = mem[wp];

  // Pointer is exactly LOG2_N bits wide, so the increment wraps N-1 -> 0 for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      for (int unsigned i = 0; i < N; i++) mem[i] <= '0;
    end else if (ce) begin
      mem[wp] <= data_in;
      wp      <= wp + 1'b1;
    end
  end

endmodule

// File: rtl/avg_filter.sv
// Boxcar moving average over the last 2**LOG2_N accepted signed samples.
module avg_filter
  import sdm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic signed [DATA_W-1:0] data_in,
  output logic signed [DATA_W-1:0] avg,
  output logic                     rdy
);

  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int N     = 1 << LOG2_N;
  localparam logic [LOG2_N:0] FILL_MAX  = (LOG2_N + 1)'(N);
  localparam logic [LOG2_N:0] FILL_LAST = (LOG2_N + 1)'(N - 1);

  logic signed [DATA_W-1:0] oldest;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  sum_next;
  logic signed [ACC_W-1:0]  in_ext;
  logic signed [ACC_W-1:0]  old_ext;
  logic signed [ACC_W-1:0]  avg_wide;
  logic        [LOG2_N:0]   fill;

  avg_filter_ring #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce      (ce),
    .data_in (data_in),
    .oldest  (oldest)
  );

  // History resets to zero, so the "oldest" term is naturally 0 during warm-up.
  always_comb begin
    in_ext   = {{LOG2_N{data_in[DATA_W-1]}}, data_in};
    old_ext  = {{LOG2_N{oldest[DATA_W-1]}}, oldest};
    sum_next = sum + in_ext - old_ext;
    avg_wide = sum_next >>> LOG2_N;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      fill <= '0;
      avg  <= '0;
      rdy  <= 1'b0;
    end else begin
      rdy <= 1'b0;
      if (ce) begin
        sum <= sum_next;
        avg <= avg_wide[DATA_W-1:0];
        rdy <= (fill >= FILL_LAST);
        if (fill != FILL_MAX) fill <= fill + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_avg_filter.sv
// Self-checking bench for avg_filter (N=4): vector tables, corner sequences, random vs. model.
module tb_avg_filter;
  import sdm_pkg::*;

  localparam int DATA_W = 16;
  localparam int LOG2_N = 2;
  localparam int N      = 1 << LOG2_N;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     ce;
  logic signed [DATA_W-1:0] data_in;
  logic signed [DATA_W-1:0] avg;
  logic                     rdy;

  int checks   = 0;
  int failures = 0;

  // Reference model: window of accepted samples, expected registered outputs.
  int hist[$];
  int m_avg = 0;
  int m_rdy = 0;

  typedef struct {
    logic ce;
    int   din;
    int   exp_avg;
    int   exp_rdy;
  } vec_t;

  vec_t vecs[8];

  avg_filter #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce      (ce),
    .data_in (data_in),
    .avg     (avg),
    .rdy     (rdy)
  );

  always #5 clk = ~clk;

  function automatic int floor_div(input int num, input int den);
    int q;
    q = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_avg = 0;
    m_rdy = 0;
  endtask

  task automatic model_edge(input logic c, input int d);
    int s;
    m_rdy = 0;
    if (c) begin
      hist.push_back(d);
      if (hist.size() > N) void'(hist.pop_front());
      s = 0;
      foreach (hist[i]) s += hist[i];
      m_avg = floor_div(s, N);
      m_rdy = (hist.size() == N) ? 1 : 0;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle after the falling edge, let the model see the rising edge, sample 1ns later.
  task automatic step(input logic c, input int d);
    @(negedge clk);
    ce      = c;
    data_in = c ? DATA_W'(d) : 'x;
    @(posedge clk);
    model_edge(c, d);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_avg"}, int'(avg), m_avg);
    check({tag, "_rdy"}, int'(rdy), m_rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ce    = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    ce      = 1'b0;
    data_in = '0;

    // Reset held with ce toggling: outputs stay cleared.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ce      = i[0];
      data_in = Q15_HALF;
      @(posedge clk);
      #1;
      check("reset_avg", int'(avg), 0);
      check("reset_rdy", int'(rdy), 0);
    end
    @(negedge clk);
    ce    = 1'b0;
    rst_n = 1'b1;
    model_reset();

    // Warm-up then steady state.
    vecs[0] = '{1'b1, 16384,   4096,  0};
    vecs[1] = '{1'b1, 8192,    6144,  0};
    vecs[2] = '{1'b1, 0,       6144,  0};
    vecs[3] = '{1'b1, -32768, -2048,  1};
    vecs[4] = '{1'b1, 16384,  -2048,  1};
    vecs[5] = '{1'b1, 16384,   0,     1};
    vecs[6] = '{1'b1, 16384,   4096,  1};
    vecs[7] = '{1'b1, 16384,   16384, 1};
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].ce, vecs[i].din);
      check("vec_avg", int'(avg), vecs[i].exp_avg);
      check("vec_rdy", int'(rdy), vecs[i].exp_rdy);
    end

    // ce gating: avg holds, rdy drops, history preserved.
    step(1'b1, 8192);
    check_model("pre_gate");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 0);
      check("gate_avg", int'(avg), m_avg);
      check("gate_rdy", int'(rdy), 0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, -4096);
      check_model("resume");
    end

    // Extremes.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, int'(Q15_MINUS_ONE));
    check("min_avg", int'(avg), -32768);
    check("min_rdy", int'(rdy), 1);
    for (int i = 0; i < 4; i++) step(1'b1, 32767);
    check("max_avg", int'(avg), 32767);

    // Async clear mid-cycle.
    #2 rst_n = 1'b0;
    #1;
    check("async_avg", int'(avg), 0);
    check("async_rdy", int'(rdy), 0);
    model_reset();
    ce = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Floor on negative odd sum.
    step(1'b1, -1);
    check("floor_avg", int'(avg), -1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 0);
      check_model("floor_tail");
    end

    // Reset mid-stream after 6 samples; warm-up restarts.
    for (int i = 0; i < 6; i++) step(1'b1, 1000 * (i + 1));
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, int'(Q15_QUARTER));
      check("rst_mid_avg", int'(avg), 2048 * (i + 1));
      check("rst_mid_rdy", int'(rdy), 0);
    end

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic c;
      int   d;
      c = ($urandom_range(0, 3) != 0);
      d = int'($signed(16'($urandom)));
      step(c, d);
      check_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
